// File: rtl/output_serializer.sv
// Snapshots a wide output-register value on start and streams it out
// least-significant word first, one word per valid/ready transfer.
module output_serializer #(
    parameter int DATA_WIDTH = 256,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  start,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_word,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int NUM_WORDS   = DATA_WIDTH / WORD_WIDTH;
    localparam int INDEX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
    } state_t;

    state_t                               state;
    state_t                               state_next;
    logic [INDEX_WIDTH-1:0]               index;
    logic [INDEX_WIDTH-1:0]               index_next;
    logic                                 load;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] snapshot;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end

    // NOTE: the snapshot is a wide register, yet it is still cleared on reset
    // so nothing from an abandoned stream can survive into the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot <= '0;
        end else if (load) begin
            snapshot <= data_in;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        index_next = index;
        load       = 1'b0;
        out_word   = '0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    index_next = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_word  = snapshot[index];
                // The final transfer leaves SEND rather than wrapping the index.
                if (out_ready) begin
                    if (index == LAST_INDEX) begin
                        index_next = '0;
                        state_next = FINISH;
                    end else begin
                        index_next = index + 1'b1;
                    end
                end
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_output_serializer;

    localparam int DW = 256;
    localparam int WW = 16;
    localparam int NW = DW / WW;

    logic          clk = 1'b1;
    logic          reset = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_word;
    logic          out_valid;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words still owed to the port, plus a pending done pulse.
    logic [WW-1:0] exp_q[$];
    bit            exp_done = 1'b0;

    output_serializer #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .start    (start),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within its time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_done = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (exp_done) begin
            exp_done = 1'b0;
        end else if (exp_q.size() != 0) begin
            if (out_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
        end else if (start) begin
            for (int i = 0; i < NW; i++) exp_q.push_back(data_in[i*WW +: WW]);
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [WW-1:0] w;
        w = (exp_q.size() != 0) ? exp_q[0] : '0;
        check({tag, ".word"},  DW'(out_word),  DW'(w));
        check({tag, ".valid"}, DW'(out_valid), DW'(exp_q.size() != 0));
        check({tag, ".busy"},  DW'(busy),      DW'((exp_q.size() != 0) || exp_done));
        check({tag, ".done"},  DW'(done),      DW'(exp_done));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs(tag);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // One stream from a start pulse; cycle 1 is the first cycle after the start edge.
    task automatic run_stream(input string tag, input logic [DW-1:0] d,
                              input int stall_at, input int stall_len,
                              input int poke_at, input bit poke_start,
                              input logic [DW-1:0] poke_data,
                              output int done_at, output int valid_cnt);
        done_at   = -1;
        valid_cnt = 0;
        data_in   = d;
        out_ready = 1'b1;
        start     = 1'b1;
        step(tag);
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (out_valid === 1'b1) valid_cnt++;
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            start     = (c == poke_at) && poke_start;
            if (c == poke_at) data_in = poke_data;
            out_ready = !(c >= stall_at && c < stall_at + stall_len);
            step(tag);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step({tag, ".after"});
    endtask

    initial begin
        logic [DW-1:0] ord_data;
        logic [DW-1:0] alt_data;
        int            done_at;
        int            valid_cnt;
        int            done_seen;

        for (int i = 0; i < NW; i++) ord_data[i*WW +: WW] = 16'h1000 + WW'(i);
        alt_data = {NW{16'hAAAA}};

        // Asynchronous reset pulsed between clock edges.
        #6;
        reset = 1'b1;
        model_reset();
        #1;
        compare_outputs("reset");
        #2;
        reset = 1'b0;
        step("idle");
        step("idle");

        // Basic stream of 5s with out_ready held high.
        run_stream("basic", {NW{16'h5555}}, 0, 0, 0, 1'b0, '0, done_at, valid_cnt);
        check("basic.done_at", DW'(done_at), DW'(17));
        check("basic.valid_cnt", DW'(valid_cnt), DW'(NW));

        // Word ordering; data_in rewritten to all A's mid-stream.
        run_stream("order", ord_data, 0, 0, 7, 1'b0, alt_data, done_at, valid_cnt);
        check("order.done_at", DW'(done_at), DW'(17));
        check("order.valid_cnt", DW'(valid_cnt), DW'(NW));

        // Backpressure: out_ready low for 4 cycles while word 3 is offered.
        run_stream("stall", ord_data, 4, 4, 0, 1'b0, '0, done_at, valid_cnt);
        check("stall.done_at", DW'(done_at), DW'(21));

        // Start with new data while word 5 is offered must be dropped.
        run_stream("busy_start", ord_data, 0, 0, 6, 1'b1, alt_data, done_at, valid_cnt);
        check("busy_start.done_at", DW'(done_at), DW'(17));
        for (int i = 0; i < 4; i++) step("busy_start.no_second");
        check("busy_start.idle_valid", DW'(out_valid), DW'(0));

        // Reset while word 8 is offered.
        data_in   = ord_data;
        out_ready = 1'b1;
        start     = 1'b1;
        step("mid_reset");
        start = 1'b0;
        for (int i = 0; i < 8; i++) step("mid_reset");
        check("mid_reset.word8", DW'(out_word), DW'(16'h1008));
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        compare_outputs("mid_reset.async");
        #1;
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step("mid_reset.quiet");
            if (done === 1'b1) done_seen++;
        end
        check("mid_reset.no_done", DW'(done_seen), DW'(0));
        run_stream("fresh", rand_data(), 0, 0, 0, 1'b0, '0, done_at, valid_cnt);
        check("fresh.done_at", DW'(done_at), DW'(17));

        // Random traffic: random data, sparse starts, random backpressure.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 60; c++) begin
                data_in   = rand_data();
                start     = ($urandom_range(0, 4) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
                step("random");
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step("drain");
        check("drain.busy", DW'(busy), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
